// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module  : led_pkg
// Brief   : Shared types, enable code and LED polarity helper for led_decoder_seq
// Rev     : 1.0 - initial release
// ============================================================================
package led_pkg;

   typedef enum logic [1:0] {
      MODE_ONEHOT = 2'd0,
      MODE_THERM  = 2'd1,
      MODE_BLINK  = 2'd2,
      MODE_CHASE  = 2'd3
   } mode_e;

   localparam logic [2:0] EN_CODE = 3'b100;

   // Maps one active-high LED bit onto the pin polarity of the bank.
   function automatic logic pat(input logic x, input logic active_low);
      return x ^ active_low;
   endfunction

endpackage
`default_nettype wire

// File: rtl/led_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : led_prescaler
// Brief   : Free-running cycle divider producing a one-cycle tick every BLINK_DIV
// Rev     : 1.0 - initial release
// ============================================================================
module led_prescaler #(
   parameter int BLINK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CNT_W-1:0] c_last = CNT_W'(BLINK_DIV - 1);

   logic [CNT_W-1:0] r_cnt;

   // clr dominates so a restart and a terminal count never both act
   assign tick = !clr && (r_cnt == c_last);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (clr || tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/led_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module  : led_decoder_seq
// Brief   : Registered select-to-LED decoder with one-hot, bar, blink and chase
// Rev     : 1.0 - initial release
// ============================================================================
module led_decoder_seq
   import led_pkg::*;
#(
   parameter int SEL_W      = 3,
   parameter int BLINK_DIV  = 4,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            enable,
   input  logic [1:0]            mode,
   input  logic [SEL_W-1:0]      switch,
   output logic [(2**SEL_W)-1:0] led
);

   localparam int         LED_W  = 2**SEL_W;
   localparam logic       c_al   = (ACTIVE_LOW != 0);
   localparam logic [LED_W-1:0] c_off  = {LED_W{c_al}};
   localparam logic [LED_W-1:0] c_ones = {LED_W{1'b1}};

   logic             r_phase;
   logic [SEL_W-1:0] r_pos;
   logic [1:0]       r_mode_q;

   logic             w_en;
   logic             w_restart;
   logic             w_tick;
   logic             w_phase_next;
   logic [SEL_W-1:0] w_pos_next;
   logic [SEL_W:0]   w_therm_sh;
   logic [LED_W-1:0] w_raw;
   logic [LED_W-1:0] w_led_next;

   assign w_en      = (enable == EN_CODE);
   assign w_restart = !w_en || (mode != r_mode_q);

   led_prescaler #(
      .BLINK_DIV (BLINK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_restart),
      .tick (w_tick)
   );

   always_comb begin
      w_phase_next = r_phase;
      w_pos_next   = r_pos;
      if (w_restart) begin
         w_phase_next = 1'b1;
         w_pos_next   = '0;
      end else if (w_tick) begin
         w_phase_next = ~r_phase;
         // pos may sit above a freshly lowered switch; wrap rather than climb
         w_pos_next   = (r_pos >= switch) ? '0 : r_pos + SEL_W'(1);
      end
   end

   // Bar of bits 0..switch: clearing everything above switch keeps switch=max in range
   assign w_therm_sh = {1'b0, switch} + (SEL_W+1)'(1);

   always_comb begin
      w_raw = '0;
      if (w_en) begin
         case (mode_e'(mode))
            MODE_ONEHOT: w_raw = LED_W'(1) << switch;
            MODE_THERM:  w_raw = ~(c_ones << w_therm_sh);
            MODE_BLINK:  w_raw = w_phase_next ? (LED_W'(1) << switch) : '0;
            MODE_CHASE:  w_raw = LED_W'(1) << w_pos_next;
            default:     w_raw = '0;
         endcase
      end
   end

   for (genvar gi = 0; gi < LED_W; gi++) begin : g_pat
      assign w_led_next[gi] = pat(w_raw[gi], c_al);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_phase  <= 1'b1;
         r_pos    <= '0;
         r_mode_q <= 2'd0;
         led      <= c_off;
      end else begin
         r_phase  <= w_phase_next;
         r_pos    <= w_pos_next;
         r_mode_q <= mode;
         led      <= w_led_next;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_led_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_decoder_seq
// Brief   : Directed self-checking bench for led_decoder_seq (SEL_W=3, DIV=4, AL=1)
// Rev     : 1.0 - initial release
// ============================================================================
module tb_led_decoder_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] enable;
   logic [1:0] mode;
   logic [2:0] switch;
   logic [7:0] led;

   int n_checks = 0;
   int n_fail   = 0;

   led_decoder_seq #(
      .SEL_W      (3),
      .BLINK_DIV  (4),
      .ACTIVE_LOW (1)
   ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .mode   (mode),
      .switch (switch),
      .led    (led)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Advance one rising edge and sample 1 time unit later
   task automatic edge_check(input string tag, input logic [7:0] exp_v);
      @(posedge clk);
      #1;
      check(tag, led, exp_v);
   endtask

   task automatic run_expect(input string tag, input logic [7:0] exp_v, input int n);
      for (int i = 0; i < n; i++) edge_check(tag, exp_v);
   endtask

   initial begin
      rst    = 1'b0;
      enable = 3'b100;
      mode   = 2'd0;
      switch = 3'd5;

      // 1. reset and one-hot
      @(posedge clk); #1;
      check("reset_off", led, 8'hFF);
      @(posedge clk); #1;
      check("reset_held", led, 8'hFF);
      rst = 1'b1;
      edge_check("onehot_sw5", 8'hDF);
      switch = 3'd0;
      edge_check("onehot_sw0", 8'hFE);

      // 2. gate and thermometer
      enable = 3'b101;
      edge_check("gate_101", 8'hFF);
      enable = 3'b000;
      edge_check("gate_000", 8'hFF);
      enable = 3'b100;
      mode   = 2'd1;
      switch = 3'd3;
      edge_check("therm_sw3", 8'hF0);
      switch = 3'd7;
      edge_check("therm_sw7", 8'h00);
      switch = 3'd0;
      edge_check("therm_sw0", 8'hFE);

      // 3. blink: 4 lit, 4 dark, repeating
      mode   = 2'd2;
      switch = 3'd2;
      for (int i = 0; i < 16; i++)
         edge_check("blink", ((i / 4) % 2 == 0) ? 8'hFB : 8'hFF);
      enable = 3'b000;
      edge_check("blink_glitch", 8'hFF);
      enable = 3'b100;
      // glitch edge already cleared the prescaler, so three more lit edges remain
      run_expect("blink_after_glitch_lit", 8'hFB, 3);
      run_expect("blink_after_glitch_dark", 8'hFF, 4);
      edge_check("blink_relit", 8'hFB);

      // 4. chase over 0..2 then mode change mid-step
      mode   = 2'd3;
      switch = 3'd2;
      run_expect("chase_p0", 8'hFE, 4);
      run_expect("chase_p1", 8'hFD, 4);
      run_expect("chase_p2", 8'hFB, 4);
      run_expect("chase_wrap", 8'hFE, 4);
      run_expect("chase_p1b", 8'hFD, 2);
      mode = 2'd0;
      edge_check("chase_to_onehot", 8'hFB);

      // 5. chase shrink: lower switch while pos=2
      mode   = 2'd3;
      switch = 3'd2;
      run_expect("shrink_p0", 8'hFE, 4);
      run_expect("shrink_p1", 8'hFD, 4);
      edge_check("shrink_p2", 8'hFB);
      switch = 3'd1;
      run_expect("shrink_hold", 8'hFB, 3);
      run_expect("shrink_wrap", 8'hFE, 4);
      run_expect("shrink_p1n", 8'hFD, 4);
      edge_check("shrink_wrap2", 8'hFE);

      // 6. asynchronous reset mid-blink
      mode   = 2'd2;
      switch = 3'd2;
      run_expect("preblink", 8'hFB, 2);
      #2 rst = 1'b0;
      #1 check("async_reset", led, 8'hFF);
      #3 rst = 1'b1;
      run_expect("post_reset_lit", 8'hFB, 4);
      edge_check("post_reset_dark", 8'hFF);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
